// File: rtl/dac_wave_gen.sv
// Multi-mode waveform generator for an N-bit ladder DAC: saw-up, saw-down, triangle, square.
// Mode and amplitude are latched only at period boundaries so the output never glitches.
module dac_wave_gen #(
  parameter int DATA_W = 4,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        k,
  input  logic [DIV_W-1:0]  div,
  input  logic [DATA_W-1:0] peak,
  output logic [DATA_W-1:0] out,
  output logic              period_start
);

  // mode       | meaning
  // MODE_SAW_UP| 0,1,..,P then boundary
  // MODE_SAW_DN| P,P-1,..,0 then boundary
  // MODE_TRI   | 0..P..1, dir tracks slope
  // MODE_SQUARE| P for P+1 ticks, 0 for P+1 ticks, ph counts within a half
  localparam logic [1:0] MODE_SAW_UP = 2'b00;
  localparam logic [1:0] MODE_SAW_DN = 2'b01;
  localparam logic [1:0] MODE_TRI    = 2'b10;
  localparam logic [1:0] MODE_SQUARE = 2'b11;

  localparam logic [DATA_W-1:0] ONE     = 1;
  localparam logic [DIV_W-1:0]  CNT_ONE = 1;

  logic [DIV_W-1:0]  cnt;
  logic              tick;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] peak_q;
  logic [DATA_W-1:0] ph;
  logic              dir;
  logic              half;
  logic              load_pend;

  logic              wrap;
  logic [DATA_W-1:0] nxt_out;
  logic [DATA_W-1:0] nxt_ph;
  logic              nxt_dir;
  logic              nxt_half;
  logic [DATA_W-1:0] start_val;

  assign tick = en && (cnt == div);

  assign start_val = (k == MODE_SAW_DN || k == MODE_SQUARE) ? peak : '0;

  always_comb begin
    wrap     = 1'b0;
    nxt_out  = out;
    nxt_ph   = ph;
    nxt_dir  = dir;
    nxt_half = half;
    // A zero-amplitude period is a single tick long in every mode.
    if (peak_q == '0) begin
      wrap = 1'b1;
    end else begin
      case (mode_q)
        MODE_SAW_UP: begin
          if (out == peak_q) wrap = 1'b1;
          else               nxt_out = out + ONE;
        end
        MODE_SAW_DN: begin
          if (out == '0) wrap = 1'b1;
          else           nxt_out = out - ONE;
        end
        MODE_TRI: begin
          if (dir) begin
            if (out == peak_q) begin
              if (peak_q == ONE) begin
                wrap = 1'b1;
              end else begin
                nxt_dir = 1'b0;
                nxt_out = out - ONE;
              end
            end else begin
              nxt_out = out + ONE;
            end
          end else begin
            if (out == ONE) wrap = 1'b1;
            else            nxt_out = out - ONE;
          end
        end
        default: begin
          if (ph == peak_q) begin
            if (half) begin
              nxt_half = 1'b0;
              nxt_ph   = '0;
              nxt_out  = '0;
            end else begin
              wrap = 1'b1;
            end
          end else begin
            nxt_ph = ph + ONE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      out          <= '0;
      period_start <= 1'b0;
      mode_q       <= MODE_SAW_UP;
      peak_q       <= '0;
      ph           <= '0;
      dir          <= 1'b1;
      half         <= 1'b1;
      load_pend    <= 1'b1;
    end else begin
      if (en) cnt <= tick ? '0 : cnt + CNT_ONE;
      if (tick) begin
        if (load_pend || wrap) begin
          mode_q       <= k;
          peak_q       <= peak;
          out          <= start_val;
          ph           <= '0;
          dir          <= 1'b1;
          half         <= 1'b1;
          load_pend    <= 1'b0;
          period_start <= 1'b1;
        end else begin
          out          <= nxt_out;
          ph           <= nxt_ph;
          dir          <= nxt_dir;
          half         <= nxt_half;
          period_start <= 1'b0;
        end
      end else begin
        period_start <= 1'b0;
      end
    end
  end

endmodule
